// File: rtl/fifo_read_adapter.sv
// Read-domain consumer for an FWFT async FIFO: pops words into a 2-entry skid buffer
// and presents them as a registered valid/ready stream, counting every delivered word.
module fifo_read_adapter #(
  parameter int unsigned data_Size  = 8,
  parameter int unsigned count_Size = 16
) (
  input  logic                  r_Clk,
  input  logic                  r_Rst,
  input  logic                  fifo_Empty,
  input  logic [data_Size-1:0]  read_Data,
  output logic                  r_Inc,
  input  logic                  drain_En,
  output logic [data_Size-1:0]  out_Data,
  output logic                  out_Valid,
  input  logic                  out_Ready,
  output logic [count_Size-1:0] word_Count,
  output logic [1:0]            buf_Occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [count_Size-1:0] CNT_STEP = count_Size'(1);

  occ_t                 state;
  logic [data_Size-1:0] head;
  logic [data_Size-1:0] tail;
  logic                 fire;

  // Pop decision looks only at local state, never at out_Ready.
  assign r_Inc    = r_Rst & drain_En & ~fifo_Empty & (state != FULL);
  assign fire     = out_Valid & out_Ready;
  assign out_Data = head;

  always_ff @(posedge r_Clk) begin
    if (!r_Rst) begin
      state      <= EMPTY;
      head       <= '0;
      tail       <= '0;
      out_Valid  <= 1'b0;
      buf_Occ    <= 2'd0;
      word_Count <= '0;
    end else begin
      if (fire) begin
        word_Count <= word_Count + CNT_STEP;
      end
      case (state)
        EMPTY: begin
          if (r_Inc) begin
            head      <= read_Data;
            state     <= ONE;
            out_Valid <= 1'b1;
            buf_Occ   <= 2'd1;
          end
        end
        ONE: begin
          case ({r_Inc, fire})
            2'b11: head <= read_Data;
            2'b10: begin
              tail    <= read_Data;
              state   <= FULL;
              buf_Occ <= 2'd2;
            end
            2'b01: begin
              state     <= EMPTY;
              out_Valid <= 1'b0;
              buf_Occ   <= 2'd0;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (fire) begin
            head    <= tail;
            state   <= ONE;
            buf_Occ <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_Valid <= 1'b0;
          buf_Occ   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_read_adapter.md
# fifo_read_adapter

Read-side consumer for the asynchronous FIFO, living entirely in the read clock domain. It pops words from the FIFO's first-word-fall-through read port and re-presents them as a registered valid/ready stream through a 2-entry skid buffer. It also keeps a running count of delivered words. It sustains one word per cycle with no combinational path from the downstream `out_Ready` back to the FIFO's `r_Inc`.

## Interface
- `data_Size`, 8, width of FIFO words and of the output stream.
- `count_Size`, 16, width of the delivered-word counter.

- `r_Clk`  in  1  read-domain clock; all state updates on its rising edge.
- `r_Rst`  in  1  reset: one clock; reset is synchronous and active-low.
- `fifo_Empty`  in  1  FIFO empty flag, synchronous to `r_Clk`.
- `read_Data`  in  `data_Size`  FIFO head word, valid whenever `fifo_Empty`=0 (first-word fall-through).
- `r_Inc`  out  1  pop strobe to the FIFO; a word is consumed on every rising edge with `r_Inc`=1.
- `drain_En`  in  1  1 = adapter may pop; 0 = stop popping, keep delivering buffered words.
- `out_Data`  out  `data_Size`  stream data.
- `out_Valid`  out  1  stream valid.
- `out_Ready`  in  1  downstream ready; transfer ("fire") = `out_Valid` & `out_Ready` at a rising edge.
- `word_Count`  out  `count_Size`  number of words fired since reset, modulo 2^`count_Size`.
- `buf_Occ`  out  2  current skid-buffer occupancy (0, 1 or 2).

## Operation
- Storage: `head` and `tail` registers, each `data_Size` wide.
- `out_Data` is `head`. `out_Valid` = (occupancy != 0).
- Pop rule (combinational): `r_Inc` = `r_Rst` & `drain_En` & ~`fifo_Empty` & (occupancy != 2). It does not depend on `out_Ready`.
- The occupancy state machine has three states, EMPTY(0), ONE(1) and FULL(2). Let push = `r_Inc` and pop = fire.
  - EMPTY with push: `head` <= `read_Data`, go to ONE.
  - EMPTY without push: stay in EMPTY. No pop is possible here because `out_Valid`=0.
  - ONE with push and pop: `head` <= `read_Data`, stay in ONE (streaming steady state).
  - ONE with push only: `tail` <= `read_Data`, go to FULL.
  - ONE with pop only: go to EMPTY.
  - ONE with neither: hold.
  - FULL with pop: `head` <= `tail`, go to ONE. Push is impossible in FULL.
  - FULL without pop: hold. `out_Data` and `out_Valid` stay stable.
- Ordering is strict FIFO: words leave in exactly the order they were popped, with no loss and no duplication.
- `word_Count` increments by 1 on each fire and wraps from 2^`count_Size`-1 to 0.
- `drain_En` falling: no further pops from the next edge on. Words already buffered still drain normally.
- `fifo_Empty` rising: no further pops. A word captured on the same edge is retained.
- Reset mid-operation discards all buffered words without delivering them.

## Timing
- Reset values, applied when `r_Rst`=0 at a rising edge:
  - occupancy 0, `out_Valid`=0, `buf_Occ`=0, `word_Count`=0.
  - `head` and `tail` = 0, so `out_Data`=0.
  - `r_Inc`=0 combinationally for as long as `r_Rst`=0.
- Latency: a word popped at edge N appears on `out_Data` with `out_Valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle while `drain_En`=1, the FIFO is non-empty and `out_Ready`=1.
- Backpressure: once `out_Ready` drops, at most 2 words are held. `r_Inc` is 0 while FULL.
- Valid/ready rules:
  - `out_Valid` never drops without a fire.
  - `out_Data` is unchanged while `out_Valid`=1 and `out_Ready`=0.
- Counter: `word_Count` updates on the same edge as the fire.

## Test plan
- Reset hold: `r_Rst`=0 for 5 cycles with `fifo_Empty`=0 and `drain_En`=1 -> `r_Inc`=0 throughout, `out_Valid`=0, `word_Count`=0, `buf_Occ`=0.
- Streaming: FIFO preloaded with 0x01..0x10, `out_Ready`=1 -> `r_Inc` high for 16 consecutive cycles, `out_Data` = 0x01..0x10 in order starting 1 cycle after the first pop, `word_Count`=16.
- Backpressure: during streaming drop `out_Ready` for 6 cycles -> `buf_Occ` reaches 2 and `r_Inc`=0; `out_Data` is held stable; after release no word is lost or duplicated.
- Alternating ready: toggle `out_Ready` every cycle over 32 words -> output order is exact and `word_Count`=32.
- Drain stop: deassert `drain_En` with 2 words buffered -> no further pops; exactly 2 more fires, then `out_Valid`=0.
- Counter wrap and reset: with `count_Size`=4, 17 fires -> `word_Count`=1; then `r_Rst`=0 with `buf_Occ`=2 -> next cycle `out_Valid`=0 and `word_Count`=0.
